// File: rtl/capture_ctrl.sv
// Capture RAM write controller: fills a circular pre-trigger buffer, arms, then
// records a programmable number of post-trigger samples and freezes the RAM.
module capture_ctrl #(
    parameter int unsigned ENTRIES = 384,
    parameter int unsigned AW      = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic          wrt_smpl,
    input  logic          triggered,
    input  logic [AW-1:0] trig_pos,
    input  logic          clr_done,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic          armed,
    output logic          capture_done,
    output logic [AW-1:0] trig_addr
);

    typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} state_t;

    localparam logic [AW-1:0] LAST = AW'(ENTRIES - 1);

    state_t        state, state_nxt;
    logic [AW-1:0] waddr_nxt, waddr_inc;
    logic [AW-1:0] cnt, cnt_nxt;
    logic [AW-1:0] p_eff, p_eff_nxt;
    logic [AW-1:0] arm_at;
    logic [AW-1:0] trig_addr_nxt;
    logic          armed_nxt, done_nxt;
    logic          active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            waddr        <= '0;
            cnt          <= '0;
            p_eff        <= '0;
            trig_addr    <= '0;
            armed        <= 1'b0;
            capture_done <= 1'b0;
        end else begin
            state        <= state_nxt;
            waddr        <= waddr_nxt;
            cnt          <= cnt_nxt;
            p_eff        <= p_eff_nxt;
            trig_addr    <= trig_addr_nxt;
            armed        <= armed_nxt;
            capture_done <= done_nxt;
        end
    end

    always_comb begin
        active        = (state == PRE) || (state == ARMED) || (state == POST);
        we            = active && run && wrt_smpl;
        waddr_inc     = (waddr == LAST) ? '0 : waddr + 1'b1;
        arm_at        = LAST - p_eff;
        state_nxt     = state;
        waddr_nxt     = we ? waddr_inc : waddr;
        cnt_nxt       = cnt;
        p_eff_nxt     = p_eff;
        trig_addr_nxt = trig_addr;
        armed_nxt     = armed;
        done_nxt      = capture_done;

        if (active && !run) begin
            state_nxt = IDLE;
            armed_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run && !capture_done) begin
                        waddr_nxt = '0;
                        cnt_nxt   = '0;
                        p_eff_nxt = (trig_pos > LAST) ? LAST : trig_pos;
                        state_nxt = PRE;
                    end
                end
                PRE: begin
                    // Arm when this write brings the count to ENTRIES-P; the count
                    // is not bumped on that write so it cannot overflow AW bits.
                    if (we) begin
                        if (cnt == arm_at) begin
                            armed_nxt = 1'b1;
                            state_nxt = ARMED;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (triggered) begin
                        trig_addr_nxt = waddr;
                        cnt_nxt       = '0;
                        if (p_eff == '0) begin
                            state_nxt = DONE;
                            armed_nxt = 1'b0;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = POST;
                        end
                    end
                end
                POST: begin
                    if (we) begin
                        cnt_nxt = cnt + 1'b1;
                        if (cnt_nxt == p_eff) begin
                            state_nxt = DONE;
                            armed_nxt = 1'b0;
                            done_nxt  = 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (clr_done) begin
                        done_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 Parameter ENTRIES, default 384, is the capture RAM depth in samples.
REQ-002 Parameter AW, default 9, is the address width and SHALL satisfy 2^AW >= ENTRIES.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 run  input  1  capture enable from the configuration register run bit; level-sensitive.
REQ-006 wrt_smpl  input  1  one-cycle strobe from the decimator: a new sample is valid this cycle.
REQ-007 triggered  input  1  combined channel/protocol trigger, valid only while armed=1.
REQ-008 trig_pos  input  AW  number of post-trigger samples to capture.
REQ-009 clr_done  input  1  one-cycle pulse from the command handler to release a finished capture.
REQ-010 we  output  1  capture RAM write enable.
REQ-011 waddr  output  AW  capture RAM write address.
REQ-012 armed  output  1  pre-trigger buffer is filled and triggers are accepted.
REQ-013 capture_done  output  1  capture is complete and the RAM is frozen.
REQ-014 trig_addr  output  AW  address written in the cycle the trigger was accepted.

Function
REQ-015 The block SHALL implement states IDLE, PRE, ARMED, POST and DONE.
REQ-016 The block SHALL use an effective post count P = min(trig_pos, ENTRIES-1), sampled when leaving IDLE and held for the whole capture.
REQ-017 In IDLE, with run=1 and capture_done=0, the block SHALL:
- clear waddr and the sample counter;
- go to PRE on the next edge.
REQ-018 In PRE, ARMED and POST, we SHALL equal wrt_smpl combinationally, and no other state SHALL assert we.
REQ-019 Each cycle with we=1, waddr SHALL advance by 1 on the next edge, wrapping from ENTRIES-1 to 0.
REQ-020 In PRE, each write SHALL increment the pre-trigger count; when that count reaches ENTRIES-P, the block SHALL set armed=1 and go to ARMED on the same edge.
REQ-021 In ARMED, when triggered=1, the block SHALL:
- load trig_addr with the current waddr;
- clear the post counter;
- go to POST, or go directly to DONE when P=0.
REQ-022 A write coinciding with the trigger cycle SHALL count as pre-trigger.
REQ-023 In POST, each write SHALL increment the post counter; the write that makes the counter equal P SHALL be performed, and the block SHALL then go to DONE.
REQ-024 On entering DONE, the block SHALL clear armed and set capture_done, and waddr SHALL hold (it points at the oldest sample).
REQ-025 In DONE, clr_done SHALL clear capture_done and return the block to IDLE; triggered and wrt_smpl SHALL be ignored.
REQ-026 run=0 in PRE, ARMED or POST SHALL abort the capture: go to IDLE, clear armed, leave capture_done=0, perform no further writes.
REQ-027 run=0 in DONE SHALL have no effect.
REQ-028 triggered SHALL be ignored in IDLE, PRE, POST and DONE.
REQ-029 clr_done SHALL be ignored outside DONE.
REQ-030 Counters SHALL be AW bits wide and SHALL never wrap within one capture.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE and set we=0, waddr=0, armed=0, capture_done=0, trig_addr=0, with all counters cleared.
REQ-032 Reset asserted mid-capture SHALL abandon the capture with no done indication.

Verification (bench with ENTRIES=8, AW=4)
REQ-033 Basic capture: trig_pos=3, run=1, wrt_smpl every cycle -> armed=1 after 5 writes (waddr=5); triggered at waddr=6 -> trig_addr=6; DONE after 3 more writes; waddr=2, capture_done=1, we=0.
REQ-034 Wrap: trig_pos=3, trigger delayed 10 samples -> waddr wraps 7->0; captured span is 8 consecutive addresses ending at waddr-1.
REQ-035 Boundaries:
- trig_pos=0 -> armed after 8 writes, DONE on the trigger edge, no post writes;
- trig_pos=15 -> clamped to 7, armed after 1 write.
REQ-036 Abort: run dropped in ARMED -> IDLE next edge, armed=0, capture_done=0, no we; reassert run -> waddr restarts at 0.
REQ-037 DONE hold: triggered and wrt_smpl toggling in DONE -> no writes, waddr stable; clr_done -> capture_done=0, IDLE.
REQ-038 Async reset in POST (between edges) -> all outputs 0 immediately, state IDLE.
